alu_arbiter: RTL and testbench

Shares one combinational ALU between NUM_REQ requesters (e.g. per-thread or per-lane issue slots) with round-robin arbitration and valid/ready request handshakes. Each accepted operation is latched into operand registers that drive the ALU. Divides (DIV, DIVI) are held for a configurable multi-cycle window so the divide path can be timed as multicycle. Results return as a one-cycle pulse tagged to the originating requester.

---
 rtl/alu_arbiter_pkg.sv | 36 +++
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter_rr_arbiter.sv | 30 +++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: operand and PC types, the opcode set,
// divide helpers and the arbiter FSM states.
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PC_W-1:0]   instruction_memory_address_t;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        ADDI = 4'd2,
        AND  = 4'd3,
        OR   = 4'd4,
        XOR  = 4'd5,
        DIV  = 4'd6,
        DIVI = 4'd7,
        JAL  = 4'd8
    } alu_instruction_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int    NUM_ALU_REQ        = 4;
    localparam int    ALU_DIV_CYCLES     = 8;
    localparam data_t DIV_BY_ZERO_RESULT = 32'hFFFF_FFFF;

    function automatic logic alu_is_divide(input alu_instruction_t instr);
        return (instr == DIV) || (instr == DIVI);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: per-requester request handshake and operands,
// plus the shared tagged response pulse.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_ALU_REQ
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    alu_instruction_t            req_instr [NUM_REQ];
    data_t                       req_op1   [NUM_REQ];
    data_t                       req_op2   [NUM_REQ];
    data_t                       req_imm   [NUM_REQ];
    instruction_memory_address_t req_pc    [NUM_REQ];

    logic [NUM_REQ-1:0]          rsp_valid;
    logic [ID_W-1:0]             rsp_id;
    data_t                       rsp_data;

    modport master (
        output req_valid, req_instr, req_op1, req_op2, req_imm, req_pc,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_instr, req_op1, req_op2, req_imm, req_pc,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first set request at or after ptr
// (wrapping) wins and is reported one-hot and as an index.
module alu_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);
    localparam int ID_W = $clog2(NUM_REQ);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant, operand
// latching, multicycle hold for divides and a tagged one-cycle result pulse.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_ALU_REQ,
    parameter int DIV_CYCLES = ALU_DIV_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    alu_arbiter_if.slave                bus,
    output alu_instruction_t            alu_instruction,
    output data_t                       alu_op1,
    output data_t                       alu_op2,
    output data_t                       alu_imm,
    output instruction_memory_address_t alu_pc,
    input  data_t                       alu_result
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    arb_state_t         state, state_next;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id;
    logic [CNT_W-1:0]   cnt;
    logic               dbz;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any;
    logic               handshake;
    logic               done;

    alu_instruction_t   sel_instr;
    data_t              divisor;
    logic               dbz_in;
    logic [CNT_W-1:0]   cnt_init;
    logic [ID_W-1:0]    ptr_next;

    alu_arbiter_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        handshake     = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                // grant is a subset of req_valid, so any grant is a handshake
                bus.req_ready = grant;
                if (any) begin
                    handshake  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Divide by zero skips the multicycle hold: its result never comes from the ALU.
    always_comb begin
        sel_instr = bus.req_instr[grant_idx];
        divisor   = (sel_instr == DIVI) ? bus.req_imm[grant_idx] : bus.req_op2[grant_idx];
        dbz_in    = alu_is_divide(sel_instr) && (divisor == '0);
        cnt_init  = (alu_is_divide(sel_instr) && !dbz_in) ? CNT_W'(DIV_CYCLES - 1) : '0;
        ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            id            <= '0;
            cnt           <= '0;
            dbz           <= 1'b0;
            bus.rsp_valid <= '0;
            bus.rsp_id    <= '0;
        end else begin
            bus.rsp_valid <= '0;
            if (handshake) begin
                ptr <= ptr_next;
                id  <= grant_idx;
                cnt <= cnt_init;
                dbz <= dbz_in;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (done) begin
                bus.rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
                bus.rsp_id    <= id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_instruction <= ADD;
            alu_op1         <= '0;
            alu_op2         <= '0;
            alu_imm         <= '0;
            alu_pc          <= '0;
            bus.rsp_data    <= '0;
        end else begin
            if (handshake) begin
                alu_instruction <= sel_instr;
                alu_op1         <= bus.req_op1[grant_idx];
                alu_op2         <= bus.req_op2[grant_idx];
                alu_imm         <= bus.req_imm[grant_idx];
                alu_pc          <= bus.req_pc[grant_idx];
            end
            if (done) begin
                bus.rsp_data <= dbz ? DIV_BY_ZERO_RESULT : alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU alongside the DUT, a cycle-level reference model
// built from grant/latency arithmetic, vector table, corner sequences and random traffic.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DC = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(N)) bus();

    alu_instruction_t            alu_instruction;
    data_t                       alu_op1, alu_op2, alu_imm, alu_result;
    instruction_memory_address_t alu_pc;

    alu_arbiter #(.NUM_REQ(N), .DIV_CYCLES(DC)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .alu_instruction (alu_instruction),
        .alu_op1         (alu_op1),
        .alu_op2         (alu_op2),
        .alu_imm         (alu_imm),
        .alu_pc          (alu_pc),
        .alu_result      (alu_result)
    );

    // ALU attached to the DUT; its divide-by-zero value is deliberately not the override
    always_comb begin
        alu_result = 32'h0;
        case (alu_instruction)
            ADD:     alu_result = alu_op1 + alu_op2;
            SUB:     alu_result = alu_op1 - alu_op2;
            ADDI:    alu_result = alu_op1 + alu_imm;
            AND:     alu_result = alu_op1 & alu_op2;
            OR:      alu_result = alu_op1 | alu_op2;
            XOR:     alu_result = alu_op1 ^ alu_op2;
            DIV:     alu_result = (alu_op2 == 0) ? 32'hDEAD_BEEF : alu_op1 / alu_op2;
            DIVI:    alu_result = (alu_imm == 0) ? 32'hDEAD_BEEF : alu_op1 / alu_imm;
            JAL:     alu_result = alu_pc + alu_imm;
            default: alu_result = 32'h0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int                          t = 0;
    int                          free_at = 0;
    int                          resp_due = -1;
    int                          m_ptr = 0;
    int                          m_resp_id = 0;
    data_t                       m_resp_data = '0;
    alu_instruction_t            m_instr = ADD;
    data_t                       m_op1 = '0, m_op2 = '0, m_imm = '0;
    instruction_memory_address_t m_pc = '0;

    logic [N-1:0] s_ready, s_rsp_valid;
    logic [1:0]   s_rsp_id;
    data_t        s_rsp_data;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic data_t ref_result(input alu_instruction_t ins, input data_t a, input data_t b,
                                         input data_t imm, input instruction_memory_address_t pc);
        case (ins)
            ADD:     return a + b;
            SUB:     return a - b;
            ADDI:    return a + imm;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            DIV:     return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIVI:    return (imm == 0) ? 32'hFFFF_FFFF : a / imm;
            JAL:     return pc + imm;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input alu_instruction_t ins, input data_t b, input data_t imm);
        if ((ins == DIV && b != 0) || (ins == DIVI && imm != 0)) return DC + 1;
        return 2;
    endfunction

    // One clock cycle: compare DUT against model, advance model, cross the edge
    task automatic step();
        int           w;
        logic [N-1:0] exp_ready, exp_v;
        #1;
        s_ready     = bus.req_ready;
        s_rsp_valid = bus.rsp_valid;
        s_rsp_id    = bus.rsp_id;
        s_rsp_data  = bus.rsp_data;
        if (t == resp_due) begin
            exp_v = '0;
            exp_v[m_resp_id] = 1'b1;
            chk("rsp_valid", 32'(s_rsp_valid), 32'(exp_v));
            chk("rsp_id", 32'(s_rsp_id), 32'(m_resp_id));
            chk("rsp_data", s_rsp_data, m_resp_data);
        end else begin
            chk("rsp_quiet", 32'(s_rsp_valid), 32'h0);
        end
        chk("alu_instruction", 32'(alu_instruction), 32'(m_instr));
        chk("alu_op1", alu_op1, m_op1);
        chk("alu_op2", alu_op2, m_op2);
        chk("alu_imm", alu_imm, m_imm);
        chk("alu_pc", alu_pc, m_pc);
        exp_ready = '0;
        w = -1;
        if (t >= free_at) begin
            w = rr_pick(bus.req_valid, m_ptr);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        chk("req_ready", 32'(s_ready), 32'(exp_ready));
        if (w >= 0) begin
            m_instr     = bus.req_instr[w];
            m_op1       = bus.req_op1[w];
            m_op2       = bus.req_op2[w];
            m_imm       = bus.req_imm[w];
            m_pc        = bus.req_pc[w];
            m_resp_id   = w;
            m_resp_data = ref_result(m_instr, m_op1, m_op2, m_imm, m_pc);
            resp_due    = t + ref_latency(m_instr, m_op2, m_imm);
            free_at     = resp_due;
            m_ptr       = (w + 1) % N;
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        bus.req_valid = '1;
        #1;
        chk("reset_ready", 32'(bus.req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("reset_rsp_data", bus.rsp_data, 32'h0);
        chk("reset_alu_instruction", 32'(alu_instruction), 32'h0);
        chk("reset_alu_op1", alu_op1, 32'h0);
        chk("reset_alu_op2", alu_op2, 32'h0);
        chk("reset_alu_imm", alu_imm, 32'h0);
        chk("reset_alu_pc", alu_pc, 32'h0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_instr = ADD; m_op1 = '0; m_op2 = '0; m_imm = '0; m_pc = '0;
        free_at = t; resp_due = -1; m_ptr = 0;
    endtask

    alu_instruction_t ops [9] = '{ADD, SUB, ADDI, AND, OR, XOR, DIV, DIVI, JAL};

    task automatic rand_inputs(input logic [N-1:0] v);
        bus.req_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.req_instr[i] = ops[$urandom_range(0, 8)];
            bus.req_op1[i]   = $urandom;
            bus.req_op2[i]   = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 100));
            bus.req_imm[i]   = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 100));
            bus.req_pc[i]    = $urandom;
        end
    endtask

    typedef struct {
        int                          id;
        alu_instruction_t            instr;
        data_t                       op1;
        data_t                       op2;
        data_t                       imm;
        instruction_memory_address_t pc;
        data_t                       exp_data;
        int                          exp_lat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int q[$];
        int lat, got, first, div_at, n3;
        data_t div_data;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int jal_order [4] = '{0, 3, 0, 3};

        tbl[0] = '{2, ADD,  32'd5,       32'd7,      32'd0,    32'h0,  32'd12,        2};
        tbl[1] = '{1, DIV,  32'd100,     32'd7,      32'd0,    32'h0,  32'd14,        DC + 1};
        tbl[2] = '{0, DIVI, 32'd50,      32'd3,      32'd0,    32'h0,  32'hFFFF_FFFF, 2};
        tbl[3] = '{3, DIV,  32'd42,      32'd0,      32'd9,    32'h0,  32'hFFFF_FFFF, 2};
        tbl[4] = '{3, JAL,  32'd1,       32'd2,      32'h10,   32'h40, 32'h50,        2};
        tbl[5] = '{1, SUB,  32'd10,      32'd3,      32'd0,    32'h0,  32'd7,         2};
        tbl[6] = '{0, DIVI, 32'd1000,    32'd0,      32'd10,   32'h0,  32'd100,       DC + 1};
        tbl[7] = '{2, XOR,  32'h0000F0F0, 32'h00000FF0, 32'd0, 32'h0,  32'h0000FF00,  2};

        rand_inputs('0);
        do_reset();

        // Directed vectors, one requester at a time
        for (int i = 0; i < 8; i++) begin
            rand_inputs('0);
            bus.req_valid[tbl[i].id] = 1'b1;
            bus.req_instr[tbl[i].id] = tbl[i].instr;
            bus.req_op1[tbl[i].id]   = tbl[i].op1;
            bus.req_op2[tbl[i].id]   = tbl[i].op2;
            bus.req_imm[tbl[i].id]   = tbl[i].imm;
            bus.req_pc[tbl[i].id]    = tbl[i].pc;
            step();
            chk("tbl_grant", 32'(s_ready), 32'(1 << tbl[i].id));
            bus.req_valid = '0;
            lat = 0;
            got = 0;
            while (!got && lat < 20) begin
                step();
                lat++;
                if (s_rsp_valid != '0) got = 1;
            end
            chk("tbl_latency", lat, tbl[i].exp_lat);
            chk("tbl_rsp_valid", 32'(s_rsp_valid), 32'(1 << tbl[i].id));
            chk("tbl_rsp_id", 32'(s_rsp_id), tbl[i].id);
            chk("tbl_rsp_data", s_rsp_data, tbl[i].exp_data);
            chk("tbl_alu_op1_hold", alu_op1, tbl[i].op1);
        end

        // All four requesting ADDI continuously: strict rotation
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.req_instr[i] = ADDI;
            bus.req_op1[i]   = 32'h0;
            bus.req_imm[i]   = 32'(i);
        end
        bus.req_valid = '1;
        q = {};
        for (int k = 0; k < 10; k++) begin
            step();
            for (int j = 0; j < N; j++) if (s_ready[j]) q.push_back(j);
        end
        chk("rr_grant_count", q.size(), 5);
        for (int j = 0; j < 5; j++) chk("rr_grant_order", (j < q.size()) ? q[j] : -1, exp_order[j]);

        // DIV holds off a competing requester until the result cycle
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_instr[1] = DIV; bus.req_op1[1] = 32'd100; bus.req_op2[1] = 32'd7;
        step();
        bus.req_valid = 4'b1000;
        bus.req_instr[3] = ADD; bus.req_op1[3] = 32'd1; bus.req_op2[3] = 32'd2;
        first = -1; div_at = -1; div_data = '0;
        for (int k = 1; k < 15; k++) begin
            step();
            if (s_rsp_valid[1]) begin div_at = k; div_data = s_rsp_data; end
            if (first < 0 && s_ready[3]) first = k;
        end
        chk("div_competitor_grant", first, DC + 1);
        chk("div_rsp_cycle", div_at, DC + 1);
        chk("div_rsp_data", div_data, 32'd14);

        // Reset in the middle of a DIV aborts it
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_instr[1] = DIV; bus.req_op1[1] = 32'd100; bus.req_op2[1] = 32'd7;
        step();
        bus.req_valid = '0;
        step();
        step();
        do_reset();
        n3 = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (s_rsp_valid != '0) n3++;
        end
        chk("abort_no_rsp", n3, 0);
        bus.req_valid = '1;
        step();
        chk("post_reset_first_grant", 32'(s_ready), 32'h1);

        // JAL from requester 3 while requester 0 toggles its valid
        do_reset();
        bus.req_instr[3] = JAL; bus.req_pc[3] = 32'h40; bus.req_imm[3] = 32'h10;
        bus.req_instr[0] = ADD; bus.req_op1[0] = 32'd3; bus.req_op2[0] = 32'd4;
        q = {};
        n3 = 0;
        for (int k = 0; k < 9; k++) begin
            bus.req_valid = {1'b1, 2'b00, (k % 2 == 0)};
            step();
            for (int j = 0; j < N; j++) if (s_ready[j]) q.push_back(j);
            if (s_rsp_valid[3] && s_rsp_id == 2'd3 && s_rsp_data == 32'h50) n3++;
        end
        for (int j = 0; j < 4; j++) chk("jal_grant_order", (j < q.size()) ? q[j] : -1, jal_order[j]);
        chk("jal_rsp_count", n3, 2);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            rand_inputs(4'($urandom_range(0, 15)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
